// File: rtl/gon_tag_sequencer_if.sv
// Tag/data FIFO handshake bundle between the GON tag sequencer and its FIFOs.
// master = sequencer side, slave = FIFO/sink side.
interface gon_tag_sequencer_if #(
    parameter int ROW_TAG_WIDTH = 4,
    parameter int COL_TAG_WIDTH = 4
);
    logic [ROW_TAG_WIDTH-1:0] row_tag;
    logic [COL_TAG_WIDTH-1:0] col_tag;
    logic                     tags_wr_en;
    logic                     tags_full;
    logic                     data_rd_en;
    logic                     data_empty;
    logic                     sink_ready;
    logic                     data_valid;

    modport master (
        output row_tag, col_tag, tags_wr_en, data_rd_en, data_valid,
        input  tags_full, data_empty, sink_ready
    );

    modport slave (
        input  row_tag, col_tag, tags_wr_en, data_rd_en, data_valid,
        output tags_full, data_empty, sink_ready
    );
endinterface

// File: rtl/gon_tag_sequencer.sv
// GON tag sequencer: issues raster-ordered row/col tags for a rows x cols x passes job
// and drains the matching data words. Optional drain watchdog under GON_SEQ_TIMEOUT_EN.
module gon_tag_sequencer #(
    parameter int ROW_TAG_WIDTH = 4,
    parameter int COL_TAG_WIDTH = 4,
    parameter int PASS_WIDTH    = 8,
    parameter int TIMEOUT_WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [ROW_TAG_WIDTH-1:0] cfg_rows,
    input  logic [COL_TAG_WIDTH-1:0] cfg_cols,
    input  logic [PASS_WIDTH-1:0]    cfg_passes,
    gon_tag_sequencer_if.master      fifo,
    output logic                     busy,
    output logic                     done,
    output logic                     timeout_err
);
    localparam int CNT_W = ROW_TAG_WIDTH + COL_TAG_WIDTH + PASS_WIDTH;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
    state_t state_q, state_d;

    logic [ROW_TAG_WIDTH-1:0] rows_q, row_q;
    logic [COL_TAG_WIDTH-1:0] cols_q, col_q;
    logic [PASS_WIDTH-1:0]    passes_q, pass_q;
    logic [CNT_W-1:0]         rd_cnt_q, total;
    logic                     data_valid_q;
    logic                     start_ok, cfg_zero, last_tag, tag_wr;
    logic                     rd_en, rd_last, rd_done, timeout_hit;

    assign total    = CNT_W'(rows_q) * CNT_W'(cols_q) * CNT_W'(passes_q);
    assign start_ok = start && (state_q == IDLE);
    assign cfg_zero = (cfg_rows == '0) || (cfg_cols == '0) || (cfg_passes == '0);
    assign last_tag = (row_q == rows_q - ROW_TAG_WIDTH'(1)) &&
                      (col_q == cols_q - COL_TAG_WIDTH'(1)) &&
                      (pass_q == passes_q - PASS_WIDTH'(1));
    assign tag_wr   = (state_q == RUN) && !fifo.tags_full;
    // Reads stop once the job total is reached even if tags are still being issued.
    assign rd_en    = ((state_q == RUN) || (state_q == DRAIN)) && (rd_cnt_q != total) &&
                      !fifo.data_empty && fifo.sink_ready;
    assign rd_last  = rd_en && (rd_cnt_q == total - CNT_W'(1));
    assign rd_done  = rd_last || (rd_cnt_q == total);

    assign fifo.row_tag    = row_q;
    assign fifo.col_tag    = col_q;
    assign fifo.tags_wr_en = tag_wr;
    assign fifo.data_rd_en = rd_en;
    assign fifo.data_valid = data_valid_q;
    assign busy            = (state_q == RUN) || (state_q == DRAIN);
    assign done            = (state_q == DONE);

`ifdef GON_SEQ_TIMEOUT_EN
    logic [TIMEOUT_WIDTH-1:0] wdog_q;
    logic                     timeout_q;

    // Fires on the idle DRAIN cycle that carries the counter to all-ones.
    assign timeout_hit = (state_q == DRAIN) && !rd_en && (wdog_q == ~TIMEOUT_WIDTH'(1));
    assign timeout_err = timeout_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wdog_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            if (start_ok)         timeout_q <= 1'b0;
            else if (timeout_hit) timeout_q <= 1'b1;
            if ((state_q == DRAIN) && !rd_en) wdog_q <= wdog_q + TIMEOUT_WIDTH'(1);
            else                              wdog_q <= '0;
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign timeout_err = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:  if (start_ok) state_d = cfg_zero ? DONE : RUN;
            RUN:   if (tag_wr && last_tag) state_d = rd_done ? DONE : DRAIN;
            DRAIN: if (rd_done || timeout_hit) state_d = DONE;
            DONE:  state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rows_q       <= '0;
            cols_q       <= '0;
            passes_q     <= '0;
            row_q        <= '0;
            col_q        <= '0;
            pass_q       <= '0;
            rd_cnt_q     <= '0;
            data_valid_q <= 1'b0;
        end else begin
            data_valid_q <= rd_en;
            if (start_ok) begin
                rows_q   <= cfg_rows;
                cols_q   <= cfg_cols;
                passes_q <= cfg_passes;
                row_q    <= '0;
                col_q    <= '0;
                pass_q   <= '0;
                rd_cnt_q <= '0;
            end else begin
                if (tag_wr) begin
                    if (col_q == cols_q - COL_TAG_WIDTH'(1)) begin
                        col_q <= '0;
                        if (row_q == rows_q - ROW_TAG_WIDTH'(1)) begin
                            row_q  <= '0;
                            pass_q <= pass_q + PASS_WIDTH'(1);
                        end else begin
                            row_q <= row_q + ROW_TAG_WIDTH'(1);
                        end
                    end else begin
                        col_q <= col_q + COL_TAG_WIDTH'(1);
                    end
                end
                if (rd_en) rd_cnt_q <= rd_cnt_q + CNT_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_gon_tag_sequencer.sv
// Randomized self-checking bench for gon_tag_sequencer against a raster-order job model.
module tb_gon_tag_sequencer;
    localparam int RW = 4, CW = 4, PW = 8, TW = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic [RW-1:0] cfg_rows = '0;
    logic [CW-1:0] cfg_cols = '0;
    logic [PW-1:0] cfg_passes = '0;
    logic          busy, done, timeout_err;

    gon_tag_sequencer_if #(.ROW_TAG_WIDTH(RW), .COL_TAG_WIDTH(CW)) fifo ();

    gon_tag_sequencer #(
        .ROW_TAG_WIDTH(RW), .COL_TAG_WIDTH(CW), .PASS_WIDTH(PW), .TIMEOUT_WIDTH(TW)
    ) dut (
        .clk(clk), .reset(reset), .start(start),
        .cfg_rows(cfg_rows), .cfg_cols(cfg_cols), .cfg_passes(cfg_passes),
        .fifo(fifo), .busy(busy), .done(done), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0, n_pass = 0;
    int cyc = 0;
    int got_tag[$], got_cyc[$], exp_tag[$];
    int rd_cnt = 0, done_cnt = 0, last_rd_cyc = 0, done_cyc = 0, proto_err = 0;
    logic prev_rd = 1'b0, prev_full = 1'b0, prev_busy = 1'b0;
    logic [RW+CW-1:0] prev_tag = '0;

    always @(posedge clk) cyc <= cyc + 1;

    // Observer: records tag writes/reads/done and flags handshake rule breaks.
    always @(negedge clk) begin
        if (reset) begin
            prev_rd = 1'b0; prev_full = 1'b0; prev_busy = 1'b0;
        end else begin
            if (fifo.data_valid !== prev_rd) proto_err++;
            if (fifo.tags_wr_en && fifo.tags_full) proto_err++;
            if (fifo.data_rd_en && (fifo.data_empty || !fifo.sink_ready)) proto_err++;
            if (busy && done) proto_err++;
            if (prev_busy && prev_full && busy && ({fifo.row_tag, fifo.col_tag} !== prev_tag)) proto_err++;
            if (fifo.tags_wr_en) begin
                got_tag.push_back(int'({fifo.row_tag, fifo.col_tag}));
                got_cyc.push_back(cyc);
            end
            if (fifo.data_rd_en) begin rd_cnt++; last_rd_cyc = cyc; end
            if (done) begin done_cnt++; done_cyc = cyc; end
            prev_rd = fifo.data_rd_en; prev_busy = busy; prev_full = fifo.tags_full;
            prev_tag = {fifo.row_tag, fifo.col_tag};
        end
    end

    task automatic fill_exp(input int r, input int c, input int p);
        exp_tag.delete();
        for (int pp = 0; pp < p; pp++)
            for (int rr = 0; rr < r; rr++)
                for (int cc = 0; cc < c; cc++)
                    exp_tag.push_back((rr << 4) | cc);
    endtask

    function automatic int first_bad(input int base);
        for (int i = 0; i < exp_tag.size(); i++) begin
            if (base + i >= got_tag.size()) return i;
            if (got_tag[base + i] != exp_tag[i]) return i;
        end
        return -1;
    endfunction

    task automatic do_start(input int r, input int c, input int p);
        @(posedge clk); #1;
        start = 1'b1; cfg_rows = RW'(r); cfg_cols = CW'(c); cfg_passes = PW'(p);
        @(negedge clk); #1;
    endtask

    // One cycle: drive inputs after the edge, return after the sampling edge. Negative empty_pct toggles.
    task automatic step(input int full_pct, input int empty_pct, input int ready_pct);
        @(posedge clk); #1;
        start = 1'b0;
        fifo.tags_full  = ($urandom_range(0, 99) < full_pct);
        fifo.data_empty = (empty_pct < 0) ? ~fifo.data_empty : ($urandom_range(0, 99) < empty_pct);
        fifo.sink_ready = ($urandom_range(0, 99) < ready_pct);
        @(negedge clk); #1;
    endtask

    task automatic test_reset();
        fifo.tags_full = 1'b0; fifo.data_empty = 1'b0; fifo.sink_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
        n_checks++; if (done !== 1'b0) $display("FAIL reset_done: got %b want 0", done); else n_pass++;
        n_checks++; if (timeout_err !== 1'b0) $display("FAIL reset_timeout: got %b want 0", timeout_err); else n_pass++;
        n_checks++; if (fifo.data_valid !== 1'b0) $display("FAIL reset_dvalid: got %b want 0", fifo.data_valid); else n_pass++;
        n_checks++; if ({fifo.row_tag, fifo.col_tag} !== 8'h00) $display("FAIL reset_tags: got %h want 00", {fifo.row_tag, fifo.col_tag}); else n_pass++;
        n_checks++; if (fifo.tags_wr_en !== 1'b0) $display("FAIL reset_wr_en: got %b want 0", fifo.tags_wr_en); else n_pass++;
        n_checks++; if (fifo.data_rd_en !== 1'b0) $display("FAIL reset_rd_en: got %b want 0", fifo.data_rd_en); else n_pass++;
        @(posedge clk); #1; reset = 1'b0;
        step(0, 0, 100);
        n_checks++; if (busy !== 1'b0) $display("FAIL idle_busy: got %b want 0", busy); else n_pass++;
    endtask

    task automatic test_raster();
        int tb = got_tag.size(), rb = rd_cnt, db = done_cnt, pb = proto_err, bad = -1, n = 0;
        fill_exp(2, 3, 1);
        fifo.tags_full = 1'b0; fifo.data_empty = 1'b0; fifo.sink_ready = 1'b1;
        do_start(2, 3, 1);
        while (done_cnt == db && n < 100) begin step(0, -1, 100); n++; end
        n_checks++; if (done_cnt - db !== 1) $display("FAIL raster_done: got %0d want 1", done_cnt - db); else n_pass++;
        n_checks++; if (got_tag.size() - tb !== 6) $display("FAIL raster_len: got %0d want 6", got_tag.size() - tb); else n_pass++;
        n_checks++; if (first_bad(tb) !== -1) $display("FAIL raster_order: first bad idx %0d want -1", first_bad(tb)); else n_pass++;
        for (int i = 0; i < 6 && tb + i < got_cyc.size(); i++)
            if (got_cyc[tb + i] - got_cyc[tb] != i) bad = i;
        n_checks++; if (bad !== -1) $display("FAIL raster_consec: gap at idx %0d want none", bad); else n_pass++;
        n_checks++; if (rd_cnt - rb !== 6) $display("FAIL raster_reads: got %0d want 6", rd_cnt - rb); else n_pass++;
        n_checks++; if (done_cyc !== last_rd_cyc + 1) $display("FAIL raster_done_cyc: got %0d want %0d", done_cyc, last_rd_cyc + 1); else n_pass++;
        n_checks++; if (proto_err - pb !== 0) $display("FAIL raster_proto: got %0d want 0", proto_err - pb); else n_pass++;
    endtask

    task automatic test_full_hold();
        int tb = got_tag.size(), rb = rd_cnt, db = done_cnt, pb = proto_err, n = 0;
        fill_exp(1, 2, 2);
        do_start(1, 2, 2);
        step(0, 0, 100);
        for (int k = 0; k < 5; k++) begin
            step(100, 0, 100);
            n_checks++;
            if (fifo.tags_wr_en !== 1'b0 || {fifo.row_tag, fifo.col_tag} !== 8'h01)
                $display("FAIL full_hold_%0d: got wr=%b tag=%h want wr=0 tag=01", k, fifo.tags_wr_en, {fifo.row_tag, fifo.col_tag});
            else n_pass++;
        end
        while (done_cnt == db && n < 100) begin step(0, 0, 100); n++; end
        n_checks++; if (got_tag.size() - tb !== 4) $display("FAIL full_len: got %0d want 4", got_tag.size() - tb); else n_pass++;
        n_checks++; if (first_bad(tb) !== -1) $display("FAIL full_order: first bad idx %0d want -1", first_bad(tb)); else n_pass++;
        n_checks++; if (rd_cnt - rb !== 4) $display("FAIL full_reads: got %0d want 4", rd_cnt - rb); else n_pass++;
        n_checks++; if (done_cnt - db !== 1) $display("FAIL full_done: got %0d want 1", done_cnt - db); else n_pass++;
        n_checks++; if (proto_err - pb !== 0) $display("FAIL full_proto: got %0d want 0", proto_err - pb); else n_pass++;
    endtask

    task automatic test_zero_cfg();
        for (int z = 0; z < 3; z++) begin
            int tb = got_tag.size(), rb = rd_cnt, db = done_cnt;
            fifo.tags_full = 1'b0; fifo.data_empty = 1'b0; fifo.sink_ready = 1'b1;
            do_start(z == 0 ? 0 : 2, z == 1 ? 0 : 3, z == 2 ? 0 : 2);
            step(0, 0, 100);
            n_checks++; if ({done, busy} !== 2'b10) $display("FAIL zero%0d_done: got done=%b busy=%b want 1/0", z, done, busy); else n_pass++;
            step(0, 0, 100);
            n_checks++; if ({done, busy} !== 2'b00) $display("FAIL zero%0d_after: got done=%b busy=%b want 0/0", z, done, busy); else n_pass++;
            n_checks++;
            if (got_tag.size() != tb || rd_cnt != rb || done_cnt - db != 1)
                $display("FAIL zero%0d_strobes: got tags=%0d reads=%0d dones=%0d want 0/0/1", z, got_tag.size() - tb, rd_cnt - rb, done_cnt - db);
            else n_pass++;
        end
    endtask

    task automatic test_start_ignored();
        int tb = got_tag.size(), rb = rd_cnt, db = done_cnt, pb = proto_err, n = 0;
        fill_exp(3, 3, 1);
        do_start(3, 3, 1);
        while (done_cnt == db && n < 300) begin
            step(30, 30, 80); n++;
            if (n == 2 || n == 5) begin start = 1'b1; cfg_rows = RW'(2); cfg_cols = CW'(2); end
        end
        start = 1'b1; cfg_rows = RW'(1); cfg_cols = CW'(1); cfg_passes = PW'(1);
        step(0, 0, 100);
        n_checks++; if ({busy, done} !== 2'b00) $display("FAIL ign_done_start: got busy=%b done=%b want 0/0", busy, done); else n_pass++;
        step(0, 0, 100);
        n_checks++; if (busy !== 1'b0) $display("FAIL ign_idle: got busy=%b want 0", busy); else n_pass++;
        n_checks++; if (got_tag.size() - tb !== 9) $display("FAIL ign_len: got %0d want 9", got_tag.size() - tb); else n_pass++;
        n_checks++; if (first_bad(tb) !== -1) $display("FAIL ign_order: first bad idx %0d want -1", first_bad(tb)); else n_pass++;
        n_checks++; if (rd_cnt - rb !== 9) $display("FAIL ign_reads: got %0d want 9", rd_cnt - rb); else n_pass++;
        n_checks++; if (done_cnt - db !== 1) $display("FAIL ign_done: got %0d want 1", done_cnt - db); else n_pass++;
        n_checks++; if (proto_err - pb !== 0) $display("FAIL ign_proto: got %0d want 0", proto_err - pb); else n_pass++;
    endtask

    task automatic test_reset_mid();
        int tb = got_tag.size(), db = done_cnt, n = 0;
        do_start(3, 3, 1);
        repeat (4) step(0, 100, 100);
        reset = 1'b1; #1;
        n_checks++; if ({busy, done, fifo.tags_wr_en} !== 3'b000) $display("FAIL rst_mid_idle: got busy=%b done=%b wr=%b want 0", busy, done, fifo.tags_wr_en); else n_pass++;
        n_checks++; if ({fifo.row_tag, fifo.col_tag} !== 8'h00) $display("FAIL rst_mid_tags: got %h want 00", {fifo.row_tag, fifo.col_tag}); else n_pass++;
        @(negedge clk); #1;
        @(posedge clk); #1; reset = 1'b0;
        repeat (2) step(0, 0, 100);
        n_checks++;
        if (got_tag.size() - tb != 4 || done_cnt != db || busy !== 1'b0)
            $display("FAIL rst_mid_abandon: got tags=%0d dones=%0d busy=%b want 4/0/0", got_tag.size() - tb, done_cnt - db, busy);
        else n_pass++;
        tb = got_tag.size(); db = done_cnt;
        fill_exp(1, 1, 1);
        do_start(1, 1, 1);
        while (done_cnt == db && n < 100) begin step(20, 20, 80); n++; end
        n_checks++; if (done_cnt - db !== 1) $display("FAIL rst_new_done: got %0d want 1", done_cnt - db); else n_pass++;
        n_checks++; if (got_tag.size() - tb !== 1 || first_bad(tb) !== -1) $display("FAIL rst_new_tags: got %0d tags want 1 tag 00", got_tag.size() - tb); else n_pass++;
    endtask

    task automatic test_random();
        for (int j = 0; j < 8; j++) begin
            int r = $urandom_range(1, 3), c = $urandom_range(1, 4), p = $urandom_range(1, 2);
            int fp = $urandom_range(0, 60), ep = $urandom_range(0, 60), rp = $urandom_range(40, 100);
            int tb = got_tag.size(), rb = rd_cnt, db = done_cnt, pb = proto_err, n = 0;
            fill_exp(r, c, p);
            do_start(r, c, p);
            while (done_cnt == db && n < 2000) begin step(fp, ep, rp); n++; end
            n_checks++;
            if (got_tag.size() - tb != r * c * p || first_bad(tb) != -1)
                $display("FAIL rand%0d_tags: got %0d first bad %0d want %0d in raster", j, got_tag.size() - tb, first_bad(tb), r * c * p);
            else n_pass++;
            n_checks++; if (rd_cnt - rb !== r * c * p) $display("FAIL rand%0d_reads: got %0d want %0d", j, rd_cnt - rb, r * c * p); else n_pass++;
            n_checks++;
            if (done_cnt - db != 1 || proto_err != pb)
                $display("FAIL rand%0d_done: got dones=%0d proto=%0d want 1/0", j, done_cnt - db, proto_err - pb);
            else n_pass++;
        end
    endtask

    task automatic test_drain_stall();
        int tb = got_tag.size(), rb = rd_cnt, db = done_cnt, n = 0;
        do_start(1, 1, 1);
        repeat (30) step(0, 100, 100);
`ifdef GON_SEQ_TIMEOUT_EN
        n_checks++; if (done_cnt - db !== 1) $display("FAIL wdog_done: got %0d want 1", done_cnt - db); else n_pass++;
        n_checks++; if (timeout_err !== 1'b1) $display("FAIL wdog_err: got %b want 1", timeout_err); else n_pass++;
        n_checks++;
        if (got_cyc.size() <= tb || done_cyc - got_cyc[tb] != 16)
            $display("FAIL wdog_timing: got %0d cycles want 16", (got_cyc.size() > tb) ? done_cyc - got_cyc[tb] : -1);
        else n_pass++;
        n_checks++; if (rd_cnt - rb !== 0) $display("FAIL wdog_reads: got %0d want 0", rd_cnt - rb); else n_pass++;
`else
        n_checks++; if (busy !== 1'b1 || done_cnt != db) $display("FAIL drain_hold: got busy=%b dones=%0d want 1/0", busy, done_cnt - db); else n_pass++;
        n_checks++; if (timeout_err !== 1'b0) $display("FAIL drain_noerr: got %b want 0", timeout_err); else n_pass++;
        while (done_cnt == db && n < 50) begin step(0, 0, 100); n++; end
        n_checks++; if (done_cnt - db !== 1 || rd_cnt - rb !== 1) $display("FAIL drain_finish: got dones=%0d reads=%0d want 1/1", done_cnt - db, rd_cnt - rb); else n_pass++;
`endif
        n_checks++; if (got_tag.size() - tb !== 1) $display("FAIL drain_tags: got %0d want 1", got_tag.size() - tb); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_raster();
        test_full_hold();
        test_zero_cfg();
        test_start_ignored();
        test_reset_mid();
        test_random();
        test_drain_stall();
        repeat (3) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not reach the summary");
        $fatal(1, "timeout");
    end
endmodule
